// File: rtl/alu_mdu.sv
// alu_mdu: execute-stage ALU with iterative radix-2 multiply/divide and HI/LO registers.
// Latency: 1 cycle for logic/arith/shift/compare ops, WIDTH+1 cycles for MULT/MULTU/DIV/DIVU.
// Backpressure: result/hi/lo held in DONE until out_ready; in_ready low during CALC and stalled DONE.
// Ports: clk, reset (async, active-high); in_valid/in_ready/op/a/b issue handshake;
//        out_valid/out_ready/result consumer handshake; hi/lo registers; busy while iterating.
module alu_mdu #(
  parameter int WIDTH     = 32,
  parameter int MULDIV_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;
  localparam logic [3:0] OP_MULT = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1101;
  localparam logic [3:0] OP_DIVU = 4'b1110;

  logic [1:0]         state;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] acc;      // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opd;      // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_lat;    // original dividend, returned in hi on divide by zero
  logic               is_div;
  logic               div_zero;
  logic               q_neg;    // negate product / quotient at the end
  logic               r_neg;    // negate remainder at the end

  logic               accept;
  logic               md_op;
  logic               sgn_op;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] step_nxt;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_fin;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_CALC);

  // With the datapath disabled, mult/div codes fall through to the reserved result of 0.
  assign md_op  = (MULDIV_EN != 0) && (op >= OP_MULT) && (op <= OP_DIVU);
  assign sgn_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag  = (sgn_op && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sgn_op && b[WIDTH-1]) ? -b : b;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLL:  alu_res = b << a[SHW-1:0];
      OP_SRL:  alu_res = b >> a[SHW-1:0];
      OP_SRA:  alu_res = $signed(b) >>> a[SHW-1:0];
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      default: alu_res = '0;
    endcase
  end

  // One radix-2 step. Multiply adds the multiplicand when the multiplier LSB is set and
  // shifts right; divide shifts the next dividend bit into the remainder and subtracts
  // when it fits (the borrow bit of the W+1-bit difference is the "does not fit" flag).
  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opd};

  always_comb begin
    step_nxt = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_trial[WIDTH])
        step_nxt = {acc[2*WIDTH-2:0], 1'b0};
      else
        step_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction on the final step's output; MIN/-1 needs no special case because
  // |MIN| as an unsigned magnitude already equals MIN and the signs match.
  assign prod_fin = q_neg ? -step_nxt : step_nxt;
  assign quo_fin  = q_neg ? -step_nxt[WIDTH-1:0] : step_nxt[WIDTH-1:0];
  assign rem_fin  = r_neg ? -step_nxt[2*WIDTH-1:WIDTH] : step_nxt[2*WIDTH-1:WIDTH];
  assign fin_hi   = is_div ? (div_zero ? a_lat : rem_fin) : prod_fin[2*WIDTH-1:WIDTH];
  assign fin_lo   = is_div ? (div_zero ? '1 : quo_fin) : prod_fin[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      opd      <= '0;
      a_lat    <= '0;
      is_div   <= 1'b0;
      div_zero <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result   <= '0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_CALC: begin
          acc <= step_nxt;
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state  <= S_DONE;
            hi     <= fin_hi;
            lo     <= fin_lo;
            result <= fin_lo;
          end
        end
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (md_op) begin
              state    <= S_CALC;
              cnt      <= CNT_LOAD;
              is_div   <= (op == OP_DIV) || (op == OP_DIVU);
              div_zero <= (b == '0);
              a_lat    <= a;
              q_neg    <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              r_neg    <= sgn_op && a[WIDTH-1];
              if ((op == OP_DIV) || (op == OP_DIVU)) begin
                acc <= {{WIDTH{1'b0}}, a_mag};
                opd <= b_mag;
              end else begin
                acc <= {{WIDTH{1'b0}}, b_mag};
                opd <= a_mag;
              end
            end else begin
              state  <= S_DONE;
              result <= alu_res;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  op;
  logic [31:0] a, b, result, hi, lo;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [3:0]  s_op;
  logic [7:0]  s_a, s_b, s_result, s_hi, s_lo;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  alu_mdu #(.WIDTH(32), .MULDIV_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .hi(hi), .lo(lo), .busy(busy)
  );

  alu_mdu #(.WIDTH(8), .MULDIV_EN(0)) dut_s (
    .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .op(s_op),
    .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready), .result(s_result),
    .hi(s_hi), .lo(s_lo), .busy(s_busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: plain 64-bit / int arithmetic straight from the op table.
  task automatic ref_model(input logic [3:0] o, input logic [31:0] x, y,
                           input logic [31:0] hi_i, lo_i,
                           output logic [31:0] r, h, l);
    longint      sp;
    logic [63:0] up;
    int          sx, sy;
    h = hi_i;
    l = lo_i;
    r = '0;
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = x - y;
      4'd4:  r = y << x[4:0];
      4'd5:  r = y >> x[4:0];
      4'd6:  r = $signed(y) >>> x[4:0];
      4'd7:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:  r = (x < y) ? 32'd1 : 32'd0;
      4'd9:  r = x ^ y;
      4'd10: r = ~(x | y);
      4'd11: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {h, l} = sp;
        r = l;
      end
      4'd12: begin
        up = {32'd0, x} * {32'd0, y};
        {h, l} = up;
        r = l;
      end
      4'd13: begin
        if (y == 0) begin
          l = 32'hFFFFFFFF; h = x;
        end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
          l = 32'h80000000; h = 32'd0;
        end else begin
          sx = x; sy = y;
          l = sx / sy; h = sx % sy;
        end
        r = l;
      end
      4'd14: begin
        if (y == 0) begin
          l = 32'hFFFFFFFF; h = x;
        end else begin
          l = x / y; h = x % y;
        end
        r = l;
      end
      default: r = '0;
    endcase
  endtask

  // Offers one op, waits for acceptance, then counts cycles until out_valid.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, y, output int lat);
    int guard;
    in_valid = 1'b1; op = o; a = x; b = y;
    guard = 0;
    while (!in_ready && guard < 100) begin tick(); guard++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_op = '0; s_a = '0; s_b = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_cmp++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_err++; $display("FAIL reset_ctrl: {out_valid,busy,in_ready}=%b required 001", {out_valid, busy, in_ready});
    end
    n_cmp++;
    if ({result, hi, lo} !== 96'd0) begin
      n_err++; $display("FAIL reset_regs: result=%h hi=%h lo=%h required 0", result, hi, lo);
    end
  endtask

  task automatic test_add_sra_back_to_back();
    int lat;
    out_ready = 1'b1;
    issue(4'd2, 32'h7FFFFFFF, 32'd1, lat);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d required 1", lat); end
    n_cmp++;
    if (result !== 32'h80000000) begin n_err++; $display("FAIL add_result: got %h required 80000000", result); end
    in_valid = 1'b1; op = 4'd6; a = 32'd4; b = 32'h80000000;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'hF8000000) begin
      n_err++; $display("FAIL sra_b2b: out_valid=%b result=%h required 1 / f8000000", out_valid, result);
    end
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_mult();
    int lat, bad, nbusy;
    logic [31:0] h0, l0;
    out_ready = 1'b0;
    h0 = 32'd0; l0 = 32'd0;
    in_valid = 1'b1; op = 4'd11; a = 32'hFFFFFFFE; b = 32'd3;
    tick();
    in_valid = 1'b0;
    lat = 1; bad = 0; nbusy = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nbusy++;
      if (!busy || in_ready || hi !== h0 || lo !== l0) bad++;
      tick();
      lat++;
    end
    n_cmp++;
    if (lat !== 33) begin n_err++; $display("FAIL mult_latency: got %0d required 33", lat); end
    n_cmp++;
    if (nbusy !== 32) begin n_err++; $display("FAIL mult_busy_cycles: got %0d required 32", nbusy); end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL mult_calc_state: %0d bad cycles required 0", bad); end
    n_cmp++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA || result !== 32'hFFFFFFFA || busy !== 1'b0) begin
      n_err++; $display("FAIL mult_result: hi=%h lo=%h result=%h busy=%b required ffffffff/fffffffa/fffffffa/0",
                        hi, lo, result, busy);
    end
    consume();
  endtask

  task automatic test_div();
    logic [3:0]  to[3];
    logic [31:0] ta[3], tb2[3], el[3], eh[3];
    int lat;
    to[0] = 4'd13; ta[0] = 32'hFFFFFFF9; tb2[0] = 32'd2;        el[0] = 32'hFFFFFFFD; eh[0] = 32'hFFFFFFFF;
    to[1] = 4'd14; ta[1] = 32'd5;        tb2[1] = 32'd0;        el[1] = 32'hFFFFFFFF; eh[1] = 32'd5;
    to[2] = 4'd13; ta[2] = 32'h80000000; tb2[2] = 32'hFFFFFFFF; el[2] = 32'h80000000; eh[2] = 32'd0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(to[i], ta[i], tb2[i], lat);
      n_cmp++;
      if (lat !== 33 || lo !== el[i] || hi !== eh[i] || result !== el[i]) begin
        n_err++; $display("FAIL div_case%0d: lat=%0d lo=%h hi=%h result=%h required 33/%h/%h/%h",
                          i, lat, lo, hi, result, el[i], eh[i], el[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat, bad;
    out_ready = 1'b0;
    issue(4'd3, 32'd3, 32'd5, lat);
    bad = 0;
    in_valid = 1'b1; op = 4'd2; a = 32'd1; b = 32'd1;
    for (int i = 0; i < 5; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'hFFFFFFFE) bad++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (bad !== 0 || result !== 32'hFFFFFFFE) begin
      n_err++; $display("FAIL backpressure_hold: %0d bad cycles, result=%h required 0 / fffffffe", bad, result);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    out_ready = 1'b0;
    in_valid = 1'b1; op = 4'd12; a = $urandom; b = $urandom;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy} !== 2'b00 || {result, hi, lo} !== 96'd0) begin
      n_err++; $display("FAIL reset_mid: out_valid=%b busy=%b result=%h hi=%h lo=%h required all 0",
                        out_valid, busy, result, hi, lo);
    end
    tick();
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
    issue(4'd8, 32'd1, 32'hFFFFFFFF, lat);
    n_cmp++;
    if (lat !== 1 || result !== 32'd1 || hi !== 32'd0 || lo !== 32'd0) begin
      n_err++; $display("FAIL sltu_after_reset: lat=%0d result=%h hi=%h lo=%h required 1/1/0/0", lat, result, hi, lo);
    end
    consume();
  endtask

  task automatic test_random();
    logic [3:0]  o;
    logic [31:0] x, y, er, eh, el;
    int lat, exp_lat, stall;
    for (int n = 0; n < 80; n++) begin
      o = 4'($urandom_range(0, 15));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: y = 32'hFFFFFFFF;
        2: y = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) x = 32'h80000000;
      ref_model(o, x, y, m_hi, m_lo, er, eh, el);
      exp_lat = (o >= 4'd11 && o <= 4'd14) ? 33 : 1;
      out_ready = 1'b0;
      issue(o, x, y, lat);
      n_cmp++;
      if (lat !== exp_lat) begin n_err++; $display("FAIL rnd_latency op=%0d: got %0d required %0d", o, lat, exp_lat); end
      stall = $urandom_range(0, 2);
      repeat (stall) tick();
      n_cmp++;
      if (out_valid !== 1'b1 || result !== er || hi !== eh || lo !== el) begin
        n_err++; $display("FAIL rnd_result op=%0d a=%h b=%h: ov=%b result=%h hi=%h lo=%h required 1/%h/%h/%h",
                          o, x, y, out_valid, result, hi, lo, er, eh, el);
      end
      m_hi = eh; m_lo = el;
      consume();
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_consume: out_valid=%b required 0", out_valid); end
    end
  endtask

  task automatic test_small_no_muldiv();
    logic [3:0] to[5];
    logic [7:0] ta[5], tb2[5], er[5];
    to[0] = 4'd4;  ta[0] = 8'h0B; tb2[0] = 8'h01; er[0] = 8'h08;
    to[1] = 4'd11; ta[1] = 8'h05; tb2[1] = 8'h07; er[1] = 8'h00;
    to[2] = 4'd2;  ta[2] = 8'hFF; tb2[2] = 8'h02; er[2] = 8'h01;
    to[3] = 4'd6;  ta[3] = 8'h0A; tb2[3] = 8'h80; er[3] = 8'hE0;
    to[4] = 4'd13; ta[4] = 8'h09; tb2[4] = 8'h00; er[4] = 8'h00;
    s_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_in_valid = 1'b1; s_op = to[i]; s_a = ta[i]; s_b = tb2[i];
      tick();
      s_in_valid = 1'b0;
      n_cmp++;
      if (s_out_valid !== 1'b1 || s_busy !== 1'b0 || s_result !== er[i] || s_hi !== 8'd0 || s_lo !== 8'd0) begin
        n_err++; $display("FAIL small_case%0d: ov=%b busy=%b result=%h hi=%h lo=%h required 1/0/%h/00/00",
                          i, s_out_valid, s_busy, s_result, s_hi, s_lo, er[i]);
      end
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add_sra_back_to_back();
    test_mult();
    test_div();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    test_small_no_muldiv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
